// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit owning HI/LO: multi-cycle mult, restoring divide, mthi/mtlo.
// Define MDU_MADD_EN to enable madd/maddu/msub/msubu (codes 7..10) accumulating into HI/LO.
module mdu_iterative #(
    parameter int unsigned MUL_CYCLES = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  mdctr,
    input  logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMthi  = 4'd5;
    localparam logic [3:0] OpMtlo  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OpMadd  = 4'd7;
    localparam logic [3:0] OpMaddu = 4'd8;
    localparam logic [3:0] OpMsub  = 4'd9;
    localparam logic [3:0] OpMsubu = 4'd10;
`endif

    localparam logic [4:0] MulCntInit = 5'(MUL_CYCLES - 1);
    localparam logic [4:0] DivCntInit = 5'd31;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

    state_e      r_state;
    logic        r_busy;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [4:0]  r_cnt;
    logic [63:0] r_prod;
    logic [31:0] r_rem;
    logic [31:0] r_quot;
    logic [31:0] r_dvs;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_dz;
`ifdef MDU_MADD_EN
    logic        r_acc_en;
    logic        r_acc_sub;
`endif

    // One shared 64x64 multiplier; operands are sign- or zero-extended, low 64 bits kept.
    logic        w_mul_signed;
    logic [63:0] w_mul_a;
    logic [63:0] w_mul_b;
    logic [63:0] w_prod;

`ifdef MDU_MADD_EN
    assign w_mul_signed = (mdctr == OpMult) || (mdctr == OpMadd) || (mdctr == OpMsub);
`else
    assign w_mul_signed = (mdctr == OpMult);
`endif
    assign w_mul_a = {{32{w_mul_signed & A[31]}}, A};
    assign w_mul_b = {{32{w_mul_signed & B[31]}}, B};
    assign w_prod  = w_mul_a * w_mul_b;

    logic        w_div_signed;
    logic [31:0] w_a_abs;
    logic [31:0] w_b_abs;

    assign w_div_signed = (mdctr == OpDiv);
    assign w_a_abs      = (w_div_signed && A[31]) ? (32'd0 - A) : A;
    assign w_b_abs      = (w_div_signed && B[31]) ? (32'd0 - B) : B;

    // Restoring step: shift rem:quot left one bit, trial subtract, keep if non-negative.
    logic [32:0] w_rem_shift;
    logic [32:0] w_trial;
    logic        w_qbit;
    logic [31:0] w_rem_next;

    assign w_rem_shift = {r_rem, r_quot[31]};
    assign w_trial     = w_rem_shift - {1'b0, r_dvs};
    assign w_qbit      = ~w_trial[32];
    assign w_rem_next  = w_qbit ? w_trial[31:0] : w_rem_shift[31:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= StIdle;
            r_busy    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_cnt     <= '0;
            r_prod    <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_dvs     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dz      <= 1'b0;
`ifdef MDU_MADD_EN
            r_acc_en  <= 1'b0;
            r_acc_sub <= 1'b0;
`endif
        end else begin
            case (r_state)
                StIdle: begin
                    if (start) begin
                        case (mdctr)
                            OpMult, OpMultu: begin
                                r_prod    <= w_prod;
                                r_cnt     <= MulCntInit;
                                r_busy    <= 1'b1;
                                r_state   <= StMul;
`ifdef MDU_MADD_EN
                                r_acc_en  <= 1'b0;
                                r_acc_sub <= 1'b0;
`endif
                            end
`ifdef MDU_MADD_EN
                            OpMadd, OpMaddu, OpMsub, OpMsubu: begin
                                r_prod    <= w_prod;
                                r_cnt     <= MulCntInit;
                                r_busy    <= 1'b1;
                                r_state   <= StMul;
                                r_acc_en  <= 1'b1;
                                r_acc_sub <= (mdctr == OpMsub) || (mdctr == OpMsubu);
                            end
`endif
                            OpDiv, OpDivu: begin
                                r_rem   <= '0;
                                r_quot  <= w_a_abs;
                                r_dvs   <= w_b_abs;
                                r_neg_q <= w_div_signed & (A[31] ^ B[31]);
                                r_neg_r <= w_div_signed & A[31];
                                r_dz    <= (B == 32'd0);
                                r_cnt   <= DivCntInit;
                                r_busy  <= 1'b1;
                                r_state <= StDiv;
                            end
                            OpMthi: r_hi <= A;
                            OpMtlo: r_lo <= A;
                            default: ;
                        endcase
                    end
                end
                StMul: begin
                    if (r_cnt == 5'd0) begin
`ifdef MDU_MADD_EN
                        // Accumulate against HI/LO as they stand now, not at issue.
                        if (!r_acc_en) begin
                            {r_hi, r_lo} <= r_prod;
                        end else if (r_acc_sub) begin
                            {r_hi, r_lo} <= {r_hi, r_lo} - r_prod;
                        end else begin
                            {r_hi, r_lo} <= {r_hi, r_lo} + r_prod;
                        end
`else
                        {r_hi, r_lo} <= r_prod;
`endif
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end else begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                StDiv: begin
                    r_rem  <= w_rem_next;
                    r_quot <= {r_quot[30:0], w_qbit};
                    if (r_cnt == 5'd0) begin
                        r_state <= StFix;
                    end else begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                StFix: begin
                    // Divide by zero still spends the full latency but leaves HI/LO untouched.
                    if (!r_dz) begin
                        r_lo <= r_neg_q ? (32'd0 - r_quot) : r_quot;
                        r_hi <= r_neg_r ? (32'd0 - r_rem) : r_rem;
                    end
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
